// File: rtl/div_ctrl.sv
// Sequencer between the EX stage and the shared pipelined divider.
// It latches one DIV/DIVU and issues it to the divider. It holds the pipeline
// until the result returns, then pulses done with HI/LO.
// Divide-by-zero is answered locally. A flush discards the result, and a
// divider that never answers is abandoned after TIMEOUT cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no op in flight; accepts start & ~flush
// ISSUE  | single-cycle request to the divider
// WAIT   | waiting for div_out_valid, counting toward TIMEOUT
// DONE   | result presented, done pulsed unless flushed
// DRAIN  | flushed op still in the divider; swallow its result
module div_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        err,
    output logic        div_rst,
    output logic        div_in_valid,
    output logic        div_sign,
    output logic [31:0] div_srca,
    output logic [31:0] div_srcb,
    input  logic        div_out_valid,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          err_q;
    logic          zero_div;
    logic          latch_ops;
    logic          cap_res;
    logic          commit;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          timeout_hit;

    assign zero_div = (srcb == '0);

    // State register; reset abandons any op without a done or err pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and datapath enables.
    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        done         = 1'b0;
        div_in_valid = 1'b0;
        latch_ops    = 1'b0;
        cap_res      = 1'b0;
        commit       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    stall     = 1'b1;
                    latch_ops = 1'b1;
                    state_nxt = zero_div ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                stall        = 1'b1;
                div_in_valid = 1'b1;
                cnt_clr      = 1'b1;
                state_nxt    = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                if (div_out_valid) begin
                    // A flush in the same cycle as the result drops it and
                    // skips DRAIN, because nothing is left in the divider.
                    cap_res   = !flush;
                    state_nxt = flush ? S_IDLE : S_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                    if (flush) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DONE: begin
                done      = !flush;
                commit    = !flush;
                state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                stall = start;
                if (div_out_valid) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand registers stay frozen from acceptance until the next IDLE accept,
    // because the divider wrapper selects its output by div_sign.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_sign <= 1'b0;
            div_srca <= '0;
            div_srcb <= '0;
        end else if (latch_ops) begin
            div_sign <= sign;
            div_srca <= srca;
            div_srcb <= srcb;
        end
    end

    // Pending result: either the divide-by-zero answer or the divider output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            res_hi <= '0;
            res_lo <= '0;
        end else if (latch_ops && zero_div) begin
            res_hi <= srca;
            res_lo <= '1;
        end else if (cap_res) begin
            res_hi <= div_hi;
            res_lo <= div_lo;
        end
    end

    // Architectural HI/LO are updated only by an unflushed DONE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end
    end

    // Wait counter and the timeout pulse that also resets the divider.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // HI/LO become visible in the done cycle itself, not one cycle later.
    assign hi_out  = commit ? res_hi : hi_q;
    assign lo_out  = commit ? res_lo : lo_q;
    assign err     = err_q;
    assign div_rst = !resetn || err_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl. A behavioural divider with programmable latency
// answers requests. Results and cycle counts are predicted from the
// architectural rules: a zero divisor gives HI=dividend and LO=all ones, and
// done follows div_out_valid by one cycle.
module tb_div_ctrl;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        sign;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        err;
    logic        div_rst;
    logic        div_in_valid;
    logic        div_sign;
    logic [31:0] div_srca;
    logic [31:0] div_srcb;
    logic        div_out_valid;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    int n_assert = 0;
    int n_fail   = 0;

    div_ctrl #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .sign         (sign),
        .srca         (srca),
        .srcb         (srcb),
        .flush        (flush),
        .stall        (stall),
        .done         (done),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .err          (err),
        .div_rst      (div_rst),
        .div_in_valid (div_in_valid),
        .div_sign     (div_sign),
        .div_srca     (div_srca),
        .div_srcb     (div_srcb),
        .div_out_valid(div_out_valid),
        .div_hi       (div_hi),
        .div_lo       (div_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural reference for one DIV/DIVU.
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
        int sa;
        int sb;
        if (b == 32'd0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else if (s) begin
            sa = a;
            sb = b;
            l  = sa / sb;
            h  = sa % sb;
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    // Behavioural divider: answers lat cycles after the request cycle.
    int          lat     = 4;
    bit          resp_en = 1'b1;
    int          cd      = 0;
    bit          nxt_ov  = 1'b0;
    bit          model_ov = 1'b0;
    bit          man_ov  = 1'b0;
    logic [31:0] p_hi = '0, p_lo = '0, nxt_hi = '0, nxt_lo = '0;
    logic [31:0] model_hi = '0, model_lo = '0;

    always @(negedge clk) begin
        nxt_ov = 1'b0;
        if (div_rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    nxt_ov = 1'b1;
                    nxt_hi = p_hi;
                    nxt_lo = p_lo;
                end
            end
            if (div_in_valid && resp_en) begin
                ref_div(div_sign, div_srca, div_srcb, p_hi, p_lo);
                cd = lat - 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        model_ov = nxt_ov;
        model_hi = nxt_hi;
        model_lo = nxt_lo;
    end

    assign div_out_valid = model_ov | man_ov;
    assign div_hi        = man_ov ? 32'hDEAD_BEEF : model_hi;
    assign div_lo        = man_ov ? 32'hBEEF_DEAD : model_lo;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Run one op with start held until done; cycle 0 is the start cycle.
    task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int l,
                         output logic [31:0] h, output logic [31:0] lq, output int dcyc,
                         output int npulse, output bit sign_hold, output bit stall_done);
        lat = l;
        tick();
        start = 1'b1;
        sign  = s;
        srca  = a;
        srcb  = b;
        #1;
        dcyc = -1; npulse = 0; sign_hold = 1'b1; stall_done = 1'b1; h = '0; lq = '0;
        for (int i = 0; i < 200; i++) begin
            if (div_in_valid) npulse++;
            if (i > 0 && div_sign !== s) sign_hold = 1'b0;
            if (done) begin
                h = hi_out; lq = lo_out; dcyc = i; stall_done = stall;
                break;
            end
            tick();
            #1;
        end
        start = 1'b0;
    endtask

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        int          l;
        logic [31:0] eh;
        logic [31:0] el;
        int          edc;
        int          epl;
    } vec_t;

    vec_t        vt[8];
    logic [31:0] exp_hi_cur, exp_lo_cur, gh, gl, eh, el, ra, rb;
    int          dcyc, npl, n_st, inv_cyc, err_cyc, n_err, n_rst, n_dn, rl;
    bit          shold, sdone, held, rs;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 32'd100,        32'd7,          8, 32'd2,          32'd14,         10, 1};
        vt[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          8, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  10, 1};
        vt[2] = '{1'b0, 32'd5,          32'd0,          4, 32'd5,          32'hFFFF_FFFF,  1,  0};
        vt[3] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          3, 32'd1,          32'h7FFF_FFFC,  5,  1};
        vt[4] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  2, 32'd1,          32'hFFFF_FFFD,  4,  1};
        vt[5] = '{1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  5, 32'hFFFF_FFFE,  32'd2,          7,  1};
        vt[6] = '{1'b0, 32'd5,          32'd10,         2, 32'd5,          32'd0,          4,  1};
        vt[7] = '{1'b1, 32'hFFFF_FFF0,  32'd0,          6, 32'hFFFF_FFF0,  32'hFFFF_FFFF,  1,  0};

        resetn = 1'b0; start = 1'b0; sign = 1'b0; srca = '0; srcb = '0; flush = 1'b0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_div_rst", div_rst, 1);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_valid", div_in_valid, 0);
        chk("rst_hi", hi_out, 0);
        chk("rst_lo", lo_out, 0);
        chk("rst_div_srca", div_srca, 0);
        tick();
        resetn = 1'b1;
        #1;
        chk("rel_div_rst", div_rst, 0);
        exp_hi_cur = '0; exp_lo_cur = '0;

        // Directed vector table
        for (int k = 0; k < 8; k++) begin
            do_op(vt[k].s, vt[k].a, vt[k].b, vt[k].l, gh, gl, dcyc, npl, shold, sdone);
            chk($sformatf("vec%0d_hi", k), gh, vt[k].eh);
            chk($sformatf("vec%0d_lo", k), gl, vt[k].el);
            chk($sformatf("vec%0d_done_cycle", k), dcyc, vt[k].edc);
            chk($sformatf("vec%0d_req_pulses", k), npl, vt[k].epl);
            chk($sformatf("vec%0d_sign_held", k), shold, 1);
            chk($sformatf("vec%0d_stall_in_done", k), sdone, 0);
            exp_hi_cur = vt[k].eh; exp_lo_cur = vt[k].el;
        end

        // Flush in IDLE: start ignored
        tick(); start = 1'b1; flush = 1'b1; srca = 32'd8; srcb = 32'd2; #1;
        chk("fidle_stall", stall, 0);
        tick(); start = 1'b0; flush = 1'b0; #1;
        chk("fidle_no_issue", div_in_valid, 0);
        chk("fidle_no_done", done, 0);

        // Flush in DONE (zero divisor): done masked, HI/LO kept
        tick(); start = 1'b1; sign = 1'b0; srca = 32'd33; srcb = 32'd0; #1;
        chk("fdone_start_stall", stall, 1);
        tick(); flush = 1'b1; start = 1'b0; #1;
        chk("fdone_masked", done, 0);
        chk("fdone_stall", stall, 0);
        tick(); flush = 1'b0; #1;
        chk("fdone_hi_kept", hi_out, exp_hi_cur);
        chk("fdone_lo_kept", lo_out, exp_lo_cur);

        // Flush 3 cycles after ISSUE, next DIVU held through DRAIN
        lat = 12;
        tick(); start = 1'b1; sign = 1'b0; srca = 32'd50; srcb = 32'd5; #1;
        tick(); #1;
        chk("fdrain_issue", div_in_valid, 1);
        tick(); lat = 5; #1;
        tick(); #1;
        tick(); flush = 1'b1; start = 1'b0; #1;
        chk("fdrain_flush_stall", stall, 1);
        tick(); flush = 1'b0; start = 1'b1; srca = 32'd91; srcb = 32'd10; #1;
        n_st = 0; inv_cyc = -1; dcyc = -1; held = 1'b1; gh = '0; gl = '0;
        for (int i = 5; i < 60; i++) begin
            if (i <= 13 && stall) n_st++;
            if (div_in_valid && inv_cyc < 0) inv_cyc = i;
            if (done) begin
                dcyc = i; gh = hi_out; gl = lo_out;
                break;
            end
            if (hi_out !== exp_hi_cur || lo_out !== exp_lo_cur) held = 1'b0;
            tick(); #1;
        end
        start = 1'b0;
        chk("fdrain_stall_cycles", n_st, 9);
        chk("fdrain_hilo_held", held, 1);
        chk("fdrain_new_issue_cycle", inv_cyc, 15);
        chk("fdrain_new_done_cycle", dcyc, 21);
        chk("fdrain_new_hi", gh, 32'd1);
        chk("fdrain_new_lo", gl, 32'd9);
        exp_hi_cur = 32'd1; exp_lo_cur = 32'd9;

        // Flush together with div_out_valid in WAIT: straight to IDLE
        lat = 4;
        tick(); start = 1'b1; sign = 1'b0; srca = 32'd20; srcb = 32'd3; #1;
        for (int i = 1; i < 5; i++) begin
            tick(); #1;
        end
        tick(); flush = 1'b1; start = 1'b0; #1;
        chk("fvalid_done_masked", done, 0);
        tick(); flush = 1'b0; start = 1'b1; #1;
        chk("fvalid_accept_stall", stall, 1);
        tick(); #1;
        chk("fvalid_reissue", div_in_valid, 1);
        dcyc = -1;
        for (int i = 7; i < 40; i++) begin
            if (done) begin
                dcyc = i; gh = hi_out; gl = lo_out;
                break;
            end
            tick(); #1;
        end
        start = 1'b0;
        chk("fvalid_done_cycle", dcyc, 12);
        chk("fvalid_hi", gh, 32'd2);
        chk("fvalid_lo", gl, 32'd6);
        exp_hi_cur = 32'd2; exp_lo_cur = 32'd6;

        // Hung divider: timeout 16 cycles after entering WAIT
        resp_en = 1'b0;
        tick(); start = 1'b1; sign = 1'b0; srca = 32'd9; srcb = 32'd3; #1;
        err_cyc = -1; n_err = 0; n_rst = 0; n_dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (err) begin
                n_err++;
                if (err_cyc < 0) err_cyc = i;
            end
            if (div_rst) n_rst++;
            if (done) n_dn++;
            tick(); start = 1'b0; #1;
        end
        chk("tmo_err_cycle", err_cyc, 18);
        chk("tmo_err_pulses", n_err, 1);
        chk("tmo_div_rst_pulses", n_rst, 1);
        chk("tmo_no_done", n_dn, 0);
        chk("tmo_idle_stall", stall, 0);
        chk("tmo_hi_kept", hi_out, exp_hi_cur);
        resp_en = 1'b1;
        do_op(1'b0, 32'd7, 32'd2, 5, gh, gl, dcyc, npl, shold, sdone);
        chk("tmo_next_hi", gh, 32'd1);
        chk("tmo_next_lo", gl, 32'd3);
        chk("tmo_next_done_cycle", dcyc, 7);
        exp_hi_cur = 32'd1; exp_lo_cur = 32'd3;

        // Reset for one cycle during WAIT, then a late result
        lat = 10;
        tick(); start = 1'b1; sign = 1'b1; srca = 32'hFFFF_FF00; srcb = 32'd3; #1;
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
        end
        tick(); resetn = 1'b0; start = 1'b0; #1;
        chk("mrst_div_rst", div_rst, 1);
        tick(); resetn = 1'b1; #1;
        chk("mrst_stall", stall, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", err, 0);
        chk("mrst_div_rst_low", div_rst, 0);
        chk("mrst_in_valid", div_in_valid, 0);
        chk("mrst_div_sign", div_sign, 0);
        chk("mrst_div_srca", div_srca, 0);
        chk("mrst_div_srcb", div_srcb, 0);
        chk("mrst_hi", hi_out, 0);
        chk("mrst_lo", lo_out, 0);
        tick(); man_ov = 1'b1; #1;
        chk("mrst_stale_no_done", done, 0);
        n_dn = 0;
        for (int i = 0; i < 15; i++) begin
            tick(); man_ov = 1'b0; #1;
            if (done) n_dn++;
        end
        chk("mrst_no_late_done", n_dn, 0);
        chk("mrst_hi_still_zero", hi_out, 0);

        // Randomized ops against the reference
        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom();
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 5);
                2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 4);
                default: rb = $urandom();
            endcase
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            rl = $urandom_range(2, 10);
            ref_div(rs, ra, rb, eh, el);
            do_op(rs, ra, rb, rl, gh, gl, dcyc, npl, shold, sdone);
            chk($sformatf("rnd%0d_hi", n), gh, eh);
            chk($sformatf("rnd%0d_lo", n), gl, el);
            chk($sformatf("rnd%0d_done_cycle", n), dcyc, (rb == 32'd0) ? 1 : rl + 2);
            chk($sformatf("rnd%0d_req_pulses", n), npl, (rb == 32'd0) ? 0 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencer between the EX stage and the shared divider wrapper (signed/unsigned pipelined divider, HI=remainder, LO=quotient). It latches operands from a DIV/DIVU instruction and issues exactly one request to the divider. It stalls the pipeline until the result returns and presents HI/LO with a one-cycle done pulse. It also handles flush by discarding in-flight results, short-circuits divide-by-zero, and recovers from a hung divider via timeout.

## Interface
- TIMEOUT, 64: max cycles waited for divider out_valid before abort (must exceed divider latency, ≥2)
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  EX stage holds a DIV/DIVU; held until done or flush
- sign  in  1  1=DIV, 0=DIVU
- srca  in  32  dividend
- srcb  in  32  divisor
- flush  in  1  exception/branch flush of EX stage
- stall  out  1  freeze pipeline (combinational)
- done  out  1  one-cycle pulse, hi_out/lo_out valid
- hi_out  out  32  remainder, held until next done
- lo_out  out  32  quotient, held until next done
- err  out  1  one-cycle pulse on timeout abort
- div_rst  out  1  active-high reset to divider: ~resetn OR timeout pulse
- div_in_valid  out  1  request to divider
- div_sign  out  1  registered sign, stable for whole op
- div_srca  out  32  registered dividend
- div_srcb  out  32  registered divisor
- div_out_valid  in  1  divider result valid
- div_hi  in  32  divider remainder
- div_lo  in  32  divider quotient

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE: on start & ~flush, latch sign/srca/srcb. If srcb==0, go to DONE with hi=srca, lo=32'hFFFFFFFF (no divider request). Otherwise go to ISSUE.
- ISSUE: div_in_valid=1 for exactly this cycle. Go to WAIT, clear counter.
- WAIT: on div_out_valid, capture div_hi/div_lo, go to DONE. Otherwise increment counter.
- DONE: done=1, stall=0. Go to IDLE. The pipeline advances at the end of this cycle, so start in the next cycle is a new instruction.
- Flush in ISSUE or WAIT: go to DRAIN; the divider request has already been issued in ISSUE. Flush in DONE: done masked, hi_out/lo_out not updated, go to IDLE. Flush in IDLE: start ignored.
- DRAIN: wait for div_out_valid, discard the result, go to IDLE. A new start during DRAIN is not accepted and raises stall.
- div_sign/div_srca/div_srcb stay constant from latch until return to IDLE. The wrapper muxes output by sign, so the sign must not change mid-op.
- Timeout: if the counter reaches TIMEOUT-1 in WAIT or DRAIN with no div_out_valid, go to IDLE next cycle. Pulse err and div_rst for one cycle. hi_out/lo_out unchanged, done not pulsed.
- div_out_valid seen in IDLE, ISSUE or DONE (stale) is ignored.

## Timing
- stall = (IDLE & start & ~flush) | ISSUE | WAIT | (DRAIN & start).
- Nonzero divide: start at cycle 0, ISSUE at cycle 1, WAIT from cycle 2. div_out_valid at cycle N gives done at N+1. Total stall is N+1 cycles.
- Zero divisor: start at cycle 0, done at cycle 1.
- Reset values (resetn low at a clock edge): state=IDLE, stall=0 (combinational from state), done=0, err=0, div_in_valid=0, div_sign=0, div_srca=0, div_srcb=0, hi_out=0, lo_out=0, counter=0.
- div_rst=1 combinationally while resetn=0.
- Reset mid-operation: abandon immediately. No done or err pulse.
- Flush and div_out_valid in the same WAIT cycle: flush wins, result discarded, go directly to IDLE (no DRAIN).

## Test plan
- DIVU 100/7, divider latency 8 -> one div_in_valid pulse, sign=0, done exactly 1 cycle after out_valid, hi_out=2, lo_out=14, stall low in DONE.
- DIV -7/2 (srca=32'hFFFFFFF9) -> div_sign=1 held through WAIT, lo_out=32'hFFFFFFFD, hi_out=32'hFFFFFFFF.
- srcb=0, srca=5 -> no div_in_valid, done at cycle 1, hi_out=5, lo_out=32'hFFFFFFFF.
- Flush 3 cycles after ISSUE, new DIVU start held during DRAIN -> stall high, stale result discarded (hi_out/lo_out keep prior values), new op issued after return to IDLE with correct result.
- Divider never asserts out_valid, TIMEOUT=16 -> err and div_rst pulse once, 16 cycles after entering WAIT; state IDLE; next op completes normally.
- resetn low for 1 cycle during WAIT -> all outputs 0 next cycle, late div_out_valid ignored, no done.
